// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding constants, ALU-control codes and the combinational
// request-to-instruction encoder used by instr_encoder.
`default_nettype none

package instr_encoder_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] FN3_ADD  = 3'b000;
  localparam logic [2:0] FN3_SLL  = 3'b001;
  localparam logic [2:0] FN3_SLT  = 3'b010;
  localparam logic [2:0] FN3_SLTU = 3'b011;
  localparam logic [2:0] FN3_XOR  = 3'b100;
  localparam logic [2:0] FN3_SR   = 3'b101;
  localparam logic [2:0] FN3_OR   = 3'b110;
  localparam logic [2:0] FN3_AND  = 3'b111;

  localparam logic [6:0] FN7_BASE = 7'b0000000;
  localparam logic [6:0] FN7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    KIND_R     = 2'b00,
    KIND_I     = 2'b01,
    KIND_LUI   = 2'b10,
    KIND_AUIPC = 2'b11
  } kind_e;

  // ALU-control codes shared with the decoder; 4'd11..4'd15 are unassigned.
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_SRA  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_e;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  function automatic enc_t encode(input logic [1:0]  kind,
                                  input logic [3:0]  alu,
                                  input logic [4:0]  rd,
                                  input logic [4:0]  rs1,
                                  input logic [4:0]  rs2,
                                  input logic [19:0] imm);
    enc_t       e;
    logic [2:0] fn3;
    logic [6:0] fn7;
    logic       known;
    logic       shift;
    e.legal = 1'b1;
    e.word  = NOP_WORD;
    fn3     = FN3_ADD;
    fn7     = FN7_BASE;
    known   = 1'b1;
    shift   = 1'b0;
    case (alu)
      ALU_SLL:  begin fn3 = FN3_SLL; shift = 1'b1; end
      ALU_SRL:  begin fn3 = FN3_SR;  shift = 1'b1; end
      ALU_SRA:  begin fn3 = FN3_SR;  fn7 = FN7_ALT; shift = 1'b1; end
      ALU_ADD:  fn3 = FN3_ADD;
      ALU_SUB:  begin fn3 = FN3_ADD; fn7 = FN7_ALT; end
      ALU_SLT:  fn3 = FN3_SLT;
      ALU_SLTU: fn3 = FN3_SLTU;
      ALU_XOR:  fn3 = FN3_XOR;
      ALU_OR:   fn3 = FN3_OR;
      ALU_AND:  fn3 = FN3_AND;
      default:  known = 1'b0;
    endcase
    case (kind)
      KIND_R: begin
        e.legal = known;
        e.word  = {fn7, rs2, rs1, fn3, rd, OP_R};
      end
      KIND_I: begin
        e.legal = known && (alu != ALU_SUB);
        e.word  = shift ? {fn7, imm[4:0], rs1, fn3, rd, OP_I}
                        : {imm[11:0], rs1, fn3, rd, OP_I};
      end
      KIND_LUI: e.word = {imm, rd, OP_LUI};
      default:  e.word = {imm, rd, OP_AUIPC};
    endcase
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fifo.sv
// DEPTH-entry 32-bit FIFO; the head word is shown combinationally, NOP when empty.
`default_nettype none

module instr_fifo
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] wdata,
  input  logic        pop,
  output logic [31:0] rdata,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? NOP_WORD : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// Encodes ALU/LUI/AUIPC requests into RV32I words queued in an output FIFO,
// flagging and counting illegal requests.
`default_nettype none

module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [1:0]  ReqKind,
  input  logic [3:0]  ReqAlu,
  input  logic [4:0]  ReqRd,
  input  logic [4:0]  ReqRs1,
  input  logic [4:0]  ReqRs2,
  input  logic [19:0] ReqImm,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] Instr,
  output logic        ErrPulse,
  output logic [7:0]  ErrCount
);

  enc_t enc;
  logic full;
  logic empty;
  logic accept;
  logic push;

  assign enc        = encode(ReqKind, ReqAlu, ReqRd, ReqRs1, ReqRs2, ReqImm);
  assign ReqReady   = !full;
  assign InstrValid = !empty;
  assign accept     = ReqValid && ReqReady;
  assign push       = accept && enc.legal;

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CPU_CLK),
    .rst   (CPU_RST),
    .push  (push),
    .wdata (enc.word),
    .pop   (InstrReady),
    .rdata (Instr),
    .full  (full),
    .empty (empty)
  );

  // Illegal requests are consumed but never enqueued.
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      ErrPulse <= 1'b0;
      ErrCount <= '0;
    end else begin
      ErrPulse <= accept && !enc.legal;
      if (accept && !enc.legal && (ErrCount != 8'hFF)) ErrCount <= ErrCount + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder with hand-computed expected words.
`default_nettype none

module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        CPU_CLK;
  logic        CPU_RST;
  logic        ReqValid;
  logic        ReqReady;
  logic [1:0]  ReqKind;
  logic [3:0]  ReqAlu;
  logic [4:0]  ReqRd;
  logic [4:0]  ReqRs1;
  logic [4:0]  ReqRs2;
  logic [19:0] ReqImm;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic        ErrPulse;
  logic [7:0]  ErrCount;

  int pass_cnt = 0;
  int total    = 0;

  instr_encoder #(.DEPTH(4)) dut (
    .CPU_CLK    (CPU_CLK),
    .CPU_RST    (CPU_RST),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqKind    (ReqKind),
    .ReqAlu     (ReqAlu),
    .ReqRd      (ReqRd),
    .ReqRs1     (ReqRs1),
    .ReqRs2     (ReqRs2),
    .ReqImm     (ReqImm),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .Instr      (Instr),
    .ErrPulse   (ErrPulse),
    .ErrCount   (ErrCount)
  );

  initial CPU_CLK = 1'b0;
  always #5 CPU_CLK = ~CPU_CLK;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [19:0] imm;
    logic [31:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge CPU_CLK);
    #1;
  endtask

  task automatic req(input logic [1:0] kind, input logic [3:0] alu, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [19:0] imm);
    ReqValid = 1'b1;
    ReqKind  = kind;
    ReqAlu   = alu;
    ReqRd    = rd;
    ReqRs1   = rs1;
    ReqRs2   = rs2;
    ReqImm   = imm;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (InstrValid !== 1'b0 || Instr !== 32'h0000_0013 || ErrPulse !== 1'b0 || ErrCount !== 8'd0) begin
      $display("FAIL reset_state: valid=%b instr=%h pulse=%b cnt=%0d, required 0/00000013/0/0",
               InstrValid, Instr, ErrPulse, ErrCount);
    end else pass_cnt++;
    @(posedge CPU_CLK);
    #1 CPU_RST = 1'b0;
    #1;
    total++;
    if (ReqReady !== 1'b1) $display("FAIL reset_ready: got %b, required 1", ReqReady);
    else pass_cnt++;
  endtask

  task automatic test_encodings();
    vec_t v [8];
    v[0] = '{2'b00, ALU_ADD, 5'd3,  5'd1,  5'd2,  20'h0,     32'h002081B3};
    v[1] = '{2'b01, ALU_ADD, 5'd1,  5'd0,  5'd0,  20'h5,     32'h00500093};
    v[2] = '{2'b01, ALU_SRA, 5'd5,  5'd6,  5'd0,  20'h3,     32'h40335293};
    v[3] = '{2'b10, ALU_ADD, 5'd7,  5'd0,  5'd0,  20'h12345, 32'h123453B7};
    v[4] = '{2'b00, ALU_SUB, 5'd1,  5'd2,  5'd3,  20'h0,     32'h403100B3};
    v[5] = '{2'b11, ALU_OR,  5'd2,  5'd0,  5'd0,  20'hABCDE, 32'hABCDE117};
    v[6] = '{2'b01, ALU_SLL, 5'd4,  5'd4,  5'd0,  20'hFFF,   32'h01F21213};
    v[7] = '{2'b00, ALU_AND, 5'd31, 5'd31, 5'd31, 20'h0,     32'h01FFFFB3};
    InstrReady = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req(v[i].kind, v[i].alu, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
      tick();
      ReqValid = 1'b0;
      total++;
      if (InstrValid !== 1'b1 || Instr !== v[i].exp)
        $display("FAIL encode_%0d: valid=%b instr=%h, required 1/%h", i, InstrValid, Instr, v[i].exp);
      else pass_cnt++;
      InstrReady = 1'b1;
      tick();
      InstrReady = 1'b0;
    end
    total++;
    if (InstrValid !== 1'b0 || Instr !== 32'h0000_0013)
      $display("FAIL empty_nop: valid=%b instr=%h, required 0/00000013", InstrValid, Instr);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [6];
    w[0] = 32'h002080B3; w[1] = 32'h00208133; w[2] = 32'h002081B3;
    w[3] = 32'h00208233; w[4] = 32'h002082B3; w[5] = 32'h00208333;
    InstrReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req(2'b00, ALU_ADD, 5'(i + 1), 5'd1, 5'd2, 20'h0);
      total++;
      if (ReqReady !== (i < 4)) $display("FAIL fill_ready_%0d: got %b, required %b", i, ReqReady, (i < 4));
      else pass_cnt++;
      if (i < 4) tick();
    end
    tick();
    tick();
    total++;
    if (ReqReady !== 1'b0 || Instr !== w[0])
      $display("FAIL full_hold: ready=%b head=%h, required 0/%h", ReqReady, Instr, w[0]);
    else pass_cnt++;
    // Pop starts; fifth request is still offered and lands alongside the next pop.
    InstrReady = 1'b1;
    tick();
    total++;
    if (ReqReady !== 1'b1 || Instr !== w[1])
      $display("FAIL drain_first: ready=%b head=%h, required 1/%h", ReqReady, Instr, w[1]);
    else pass_cnt++;
    tick();
    req(2'b00, ALU_ADD, 5'd6, 5'd1, 5'd2, 20'h0);
    total++;
    if (ReqReady !== 1'b1 || Instr !== w[2])
      $display("FAIL push_pop_1: ready=%b head=%h, required 1/%h", ReqReady, Instr, w[2]);
    else pass_cnt++;
    tick();
    ReqValid = 1'b0;
    for (int k = 3; k < 6; k++) begin
      total++;
      if (InstrValid !== 1'b1 || Instr !== w[k])
        $display("FAIL drain_order_%0d: valid=%b head=%h, required 1/%h", k, InstrValid, Instr, w[k]);
      else pass_cnt++;
      tick();
    end
    total++;
    if (InstrValid !== 1'b0) $display("FAIL drained_empty: valid=%b, required 0", InstrValid);
    else pass_cnt++;
    InstrReady = 1'b0;
  endtask

  task automatic test_illegal();
    req(2'b01, ALU_SUB, 5'd1, 5'd2, 5'd3, 20'h0);
    tick();
    ReqValid = 1'b0;
    total++;
    if (ErrPulse !== 1'b1 || ErrCount !== 8'd1 || InstrValid !== 1'b0)
      $display("FAIL illegal_isub: pulse=%b cnt=%0d valid=%b, required 1/1/0", ErrPulse, ErrCount, InstrValid);
    else pass_cnt++;
    tick();
    total++;
    if (ErrPulse !== 1'b0) $display("FAIL err_pulse_width: got %b, required 0", ErrPulse);
    else pass_cnt++;
    req(2'b00, ALU_LUI, 5'd1, 5'd2, 5'd3, 20'h0);
    tick();
    req(2'b01, 4'hF, 5'd1, 5'd2, 5'd3, 20'h0);
    tick();
    req(2'b10, 4'hF, 5'd7, 5'd0, 5'd0, 20'h12345);
    tick();
    ReqValid = 1'b0;
    total++;
    if (ErrCount !== 8'd3 || ErrPulse !== 1'b0 || InstrValid !== 1'b1 || Instr !== 32'h123453B7)
      $display("FAIL illegal_mix: cnt=%0d pulse=%b valid=%b instr=%h, required 3/0/1/123453B7",
               ErrCount, ErrPulse, InstrValid, Instr);
    else pass_cnt++;
    InstrReady = 1'b1;
    tick();
    InstrReady = 1'b0;
    req(2'b00, 4'hC, 5'd1, 5'd1, 5'd1, 20'h0);
    repeat (300) tick();
    ReqValid = 1'b0;
    total++;
    if (ErrCount !== 8'd255 || ErrPulse !== 1'b1 || InstrValid !== 1'b0)
      $display("FAIL err_saturate: cnt=%0d pulse=%b valid=%b, required 255/1/0", ErrCount, ErrPulse, InstrValid);
    else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    InstrReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(2'b01, ALU_XOR, 5'(i + 8), 5'd3, 5'd0, 20'h0FF);
      tick();
    end
    ReqValid = 1'b0;
    total++;
    if (InstrValid !== 1'b1) $display("FAIL pre_reset_valid: got %b, required 1", InstrValid);
    else pass_cnt++;
    #2 CPU_RST = 1'b1;
    #1;
    total++;
    if (InstrValid !== 1'b0 || Instr !== 32'h0000_0013 || ErrCount !== 8'd0 || ErrPulse !== 1'b0)
      $display("FAIL async_reset: valid=%b instr=%h cnt=%0d pulse=%b, required 0/00000013/0/0",
               InstrValid, Instr, ErrCount, ErrPulse);
    else pass_cnt++;
    tick();
    CPU_RST = 1'b0;
    InstrReady = 1'b1;
    tick();
    tick();
    total++;
    if (InstrValid !== 1'b0 || ReqReady !== 1'b1 || Instr !== 32'h0000_0013)
      $display("FAIL post_reset_idle: valid=%b ready=%b instr=%h, required 0/1/00000013",
               InstrValid, ReqReady, Instr);
    else pass_cnt++;
  endtask

  initial begin
    CPU_RST    = 1'b1;
    ReqValid   = 1'b0;
    ReqKind    = 2'b00;
    ReqAlu     = 4'd0;
    ReqRd      = 5'd0;
    ReqRs1     = 5'd0;
    ReqRs2     = 5'd0;
    ReqImm     = 20'h0;
    InstrReady = 1'b0;
    test_reset();
    test_encodings();
    test_back_to_back();
    test_illegal();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire
